// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver with frame-aligned staged
// loading, per-digit decimal points, leading-zero blanking and PWM brightness.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned SCAN_DIV   = 17,
    parameter int unsigned DUTY_BITS  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lz_blank,
    input  logic [DUTY_BITS-1:0]      brightness,
    output logic [NUM_DIGITS-1:0]     whichLight,
    output logic [6:0]                whichPipe,
    output logic                      dp,
    output logic                      frame_start,
    output logic                      pending
);

    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV-1:0] TICK_MAX = '1;

    function automatic logic [6:0] hex_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b0000001;
            4'h1: seg = 7'b1001111;
            4'h2: seg = 7'b0010010;
            4'h3: seg = 7'b0000110;
            4'h4: seg = 7'b1001100;
            4'h5: seg = 7'b0100100;
            4'h6: seg = 7'b0100000;
            4'h7: seg = 7'b0001111;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0000100;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b1100000;
            4'hC: seg = 7'b0110001;
            4'hD: seg = 7'b1000010;
            4'hE: seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    logic [SCAN_DIV-1:0]   tick_q, tick_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_W-1:0]     disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [DATA_W-1:0]     stage_data_q, stage_data_d;
    logic [NUM_DIGITS-1:0] stage_dp_q, stage_dp_d;
    logic                  pending_q, pending_d;
    logic                  frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0] light_q, light_d;
    logic [6:0]            pipe_q, pipe_d;
    logic                  dp_q, dp_d;

    logic                  slot_end;
    logic                  boundary;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  zero_run;
    logic [DUTY_BITS-1:0]  phase;
    logic                  lit;

    // Scan counters, staging and frame-boundary commit
    always_comb begin
        tick_d        = tick_q + SCAN_DIV'(1);
        idx_d         = idx_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        stage_data_d  = stage_data_q;
        stage_dp_d    = stage_dp_q;
        pending_d     = pending_q;
        slot_end      = (tick_q == TICK_MAX);
        boundary      = slot_end && (idx_q == LAST_IDX);
        frame_start_d = boundary;

        if (slot_end) begin
            idx_d = boundary ? '0 : idx_q + IDX_W'(1);
        end
        if (boundary && pending_q) begin
            disp_data_d = stage_data_q;
            disp_dp_d   = stage_dp_q;
            pending_d   = 1'b0;
        end
        // A load on the boundary cycle is staged for the following frame
        if (load) begin
            stage_data_d = data_in;
            stage_dp_d   = dp_in;
            pending_d    = 1'b1;
        end
    end

    // Current-digit selection, leading-zero detection and PWM gating
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            zero_run = zero_run & (disp_data_q[4*(int'(NUM_DIGITS)-1-i) +: 4] == 4'h0);
            if (idx_q == IDX_W'(i)) begin
                cur_nib   = disp_data_q[4*(int'(NUM_DIGITS)-1-i) +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = lz_blank && zero_run && (i != int'(NUM_DIGITS) - 1);
            end
        end

        phase   = tick_q[SCAN_DIV-1 -: DUTY_BITS];
        lit     = (phase <= brightness);
        light_d = '1;
        pipe_d  = 7'b1111111;
        dp_d    = 1'b1;
        if (lit) begin
            light_d = ~(NUM_DIGITS'(1) << idx_q);
            pipe_d  = cur_blank ? 7'b1111111 : hex_seg(cur_nib);
            dp_d    = ~cur_dp;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q        <= '0;
            idx_q         <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            stage_data_q  <= '0;
            stage_dp_q    <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
            light_q       <= '1;
            pipe_q        <= 7'b1111111;
            dp_q          <= 1'b1;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            stage_data_q  <= stage_data_d;
            stage_dp_q    <= stage_dp_d;
            pending_q     <= pending_d;
            frame_start_q <= frame_start_d;
            light_q       <= light_d;
            pipe_q        <= pipe_d;
            dp_q          <= dp_d;
        end
    end

    assign whichLight  = light_q;
    assign whichPipe   = pipe_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;
    assign pending     = pending_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: frame-by-frame pin checks against
// hand-tabulated segment codes, staged loading, blanking, brightness, reset.
module tb_seg7_scan_driver;

    localparam int unsigned ND = 8;
    localparam int unsigned SD = 4;
    localparam int unsigned DB = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [4*ND-1:0] data_in;
    logic [ND-1:0]   dp_in;
    logic            load;
    logic            lz_blank;
    logic [DB-1:0]   brightness;
    logic [ND-1:0]   whichLight;
    logic [6:0]      whichPipe;
    logic            dp;
    logic            frame_start;
    logic            pending;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DUTY_BITS(DB)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .load(load),
        .lz_blank(lz_blank), .brightness(brightness), .whichLight(whichLight),
        .whichPipe(whichPipe), .dp(dp), .frame_start(frame_start), .pending(pending)
    );

    logic [6:0] seg_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                 7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    int n_checks = 0;
    int n_fail   = 0;

    int          load_at  [3];
    logic [31:0] load_val [3];
    logic [7:0]  load_dpv [3];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_loads();
        for (int k = 0; k < 3; k++) begin
            load_at[k]  = -1;
            load_val[k] = '0;
            load_dpv[k] = '0;
        end
    endtask

    task automatic set_load(input int k, input int at, input logic [31:0] v, input logic [7:0] d);
        load_at[k]  = at;
        load_val[k] = v;
        load_dpv[k] = d;
    endtask

    // Advance to the frame_start pulse, then one more cycle to digit 0 / phase 0
    task automatic wait_frame(input logic exp_pend);
        int waited = 0;
        while (frame_start !== 1'b1 && waited < 400) begin
            step();
            waited++;
        end
        check_val("frame_start_seen", 32'(frame_start), 32'd1);
        check_val("pending_at_boundary", 32'(pending), 32'(exp_pend));
        step();
    endtask

    // Check all 128 cycles of one frame, applying any scheduled loads on the way
    task automatic check_frame(input logic [31:0] val, input logic [7:0] dpv, input logic [3:0] bright);
        logic [7:0] exp_light;
        logic [6:0] exp_pipe;
        logic       exp_dp;
        logic [3:0] nib;
        logic       en;
        logic       blank;
        int         lit_cnt;
        int         j;
        for (int d = 0; d < 8; d++) begin
            lit_cnt = 0;
            nib     = val[4*(7-d) +: 4];
            blank   = lz_blank && (d < 7) && ((val >> (28 - 4*d)) == 32'd0);
            for (int p = 0; p < 16; p++) begin
                j         = d*16 + p;
                en        = (p <= int'(bright));
                exp_light = en ? ~(8'd1 << d) : 8'hFF;
                exp_pipe  = en ? (blank ? 7'h7F : seg_tab[nib]) : 7'h7F;
                exp_dp    = en ? ~dpv[d] : 1'b1;
                check_val($sformatf("whichLight d%0d p%0d", d, p), 32'(whichLight), 32'(exp_light));
                check_val($sformatf("whichPipe d%0d p%0d", d, p), 32'(whichPipe), 32'(exp_pipe));
                check_val($sformatf("dp d%0d p%0d", d, p), 32'(dp), 32'(exp_dp));
                check_val($sformatf("frame_start j%0d", j), 32'(frame_start), 32'(j == 127));
                for (int k = 0; k < 3; k++)
                    if (load_at[k] >= 0 && load_at[k] + 1 == j)
                        check_val($sformatf("pending after load j%0d", j), 32'(pending), 32'd1);
                if (whichLight != 8'hFF) lit_cnt++;
                if (j < 127) begin
                    for (int k = 0; k < 3; k++)
                        if (load_at[k] == j) begin
                            data_in = load_val[k];
                            dp_in   = load_dpv[k];
                            load    = 1'b1;
                        end
                    step();
                    load    = 1'b0;
                    data_in = '1;
                    dp_in   = '1;
                end
            end
            check_val($sformatf("lit cycles d%0d", d), 32'(lit_cnt), 32'(int'(bright) + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset      = 1'b1;
        load       = 1'b0;
        data_in    = '1;
        dp_in      = '1;
        lz_blank   = 1'b0;
        brightness = 4'hF;
        clear_loads();
        repeat (3) step();
        check_val("reset whichLight", 32'(whichLight), 32'hFF);
        check_val("reset whichPipe", 32'(whichPipe), 32'h7F);
        check_val("reset dp", 32'(dp), 32'd1);
        check_val("reset frame_start", 32'(frame_start), 32'd0);
        check_val("reset pending", 32'(pending), 32'd0);
        reset = 1'b0;
        step();

        // First frame shows zeros; load 12345678 during it
        set_load(0, 30, 32'h12345678, 8'h00);
        check_frame(32'h0, 8'h00, 4'hF);
        clear_loads();
        wait_frame(1'b0);

        // Mid-frame load during digit 3 must not disturb this frame
        set_load(0, 53, 32'hABCDEF00, 8'hA5);
        check_frame(32'h12345678, 8'h00, 4'hF);
        clear_loads();
        wait_frame(1'b0);

        // Two loads in-frame plus one coincident with the boundary
        set_load(0, 10, 32'h11111111, 8'h00);
        set_load(1, 50, 32'h22222222, 8'h00);
        set_load(2, 126, 32'h33333333, 8'h00);
        check_frame(32'hABCDEF00, 8'hA5, 4'hF);
        clear_loads();
        wait_frame(1'b1);
        check_frame(32'h22222222, 8'h00, 4'hF);
        lz_blank = 1'b1;
        wait_frame(1'b0);

        // Leading-zero blanking
        set_load(0, 20, 32'h00000450, 8'h00);
        check_frame(32'h33333333, 8'h00, 4'hF);
        clear_loads();
        wait_frame(1'b0);
        set_load(0, 20, 32'h00000000, 8'h01);
        check_frame(32'h00000450, 8'h00, 4'hF);
        clear_loads();
        wait_frame(1'b0);
        set_load(0, 20, 32'h12345678, 8'h00);
        check_frame(32'h00000000, 8'h01, 4'hF);
        clear_loads();
        lz_blank   = 1'b0;
        brightness = 4'h0;
        wait_frame(1'b0);

        // Brightness duty
        check_frame(32'h12345678, 8'h00, 4'h0);
        brightness = 4'h7;
        wait_frame(1'b0);
        check_frame(32'h12345678, 8'h00, 4'h7);
        wait_frame(1'b0);

        // Reset during digit 5 with a staged value pending
        repeat (85) step();
        data_in = 32'h9ABCDEF0;
        dp_in   = 8'hFF;
        load    = 1'b1;
        step();
        load    = 1'b0;
        data_in = '1;
        check_val("pending before reset", 32'(pending), 32'd1);
        reset = 1'b1;
        step();
        check_val("midreset whichLight", 32'(whichLight), 32'hFF);
        check_val("midreset whichPipe", 32'(whichPipe), 32'h7F);
        check_val("midreset dp", 32'(dp), 32'd1);
        check_val("midreset frame_start", 32'(frame_start), 32'd0);
        check_val("midreset pending", 32'(pending), 32'd0);
        reset = 1'b0;
        step();
        check_frame(32'h0, 8'h00, 4'h7);
        wait_frame(1'b0);
        check_frame(32'h0, 8'h00, 4'h7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
